// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state
// encodings and small op-decoding helpers.
package muldiv_unit_pkg;

  // Op encodings as delivered by the decoder for hilo-class instructions
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // FSM state encodings
  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_ITER = 2'd1;
  localparam logic [1:0] MDU_FIX  = 2'd2;
  localparam logic [1:0] MDU_DONE = 2'd3;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_iter_core.sv
// One iteration step of the multiply/divide datapath, purely combinational.
// Multiply: shift-add with the multiplier in lo and the partial product in hi.
// Divide: restoring step with the dividend shifting out of lo into the
// partial remainder in hi, quotient bits shifting into lo.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Compute both step flavours and select by operation
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    ge      = shifted >= {1'b0, operand};
    // When ge holds the true difference is below operand, so WIDTH bits suffice
    diff    = shifted[WIDTH-1:0] - operand;
    if (is_div) begin
      hi_out = ge ? diff : shifted[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], ge};
    end else begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit producing HI/LO for MULT, MULTU, DIV, DIVU.
// Signed ops run on magnitudes; the FIX cycle applies the result signs and
// the divide-by-zero / signed-overflow special cases.
// Optional feature macro: MDU_FAST_MUL_EN -- MULT/MULTU complete through a
// single-cycle array multiply (done one cycle after start, busy stays low).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CW-1:0]    count;
  logic             op_div;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] operand_mag;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic             neg_prod;
  logic             neg_rem;
  logic             div_zero;
  logic             div_ovf;

  logic             accept;
  logic             fast;
  logic             in_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign busy = (state == MDU_ITER) || (state == MDU_FIX);
  assign done = (state == MDU_DONE);

  // Operand sign extraction and magnitudes for the incoming request
  assign in_signed = op_is_signed(op);
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Sign-extend to full width so one truncated product covers both MULT and MULTU
  assign fast_prod = {{WIDTH{a_neg}}, a} * {{WIDTH{b_neg}}, b};
`endif

  // Request acceptance: only from IDLE or DONE, and flush always wins
  always_comb begin
    accept = start && !flush && ((state == MDU_IDLE) || (state == MDU_DONE));
    fast   = 1'b0;
`ifdef MDU_FAST_MUL_EN
    fast   = accept && !op_is_div(op);
`endif
  end

  // Next-state logic for IDLE -> ITER -> FIX -> DONE
  always_comb begin
    state_next = state;
    case (state)
      MDU_ITER: if (count == '0) state_next = MDU_FIX;
      MDU_FIX:  state_next = MDU_DONE;
      default: begin
        if (accept)                 state_next = fast ? MDU_DONE : MDU_ITER;
        else if (state == MDU_DONE) state_next = MDU_IDLE;
      end
    endcase
    if (flush) state_next = MDU_IDLE;
  end

  mdu_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .is_div (op_div),
    .hi_in  (work_hi),
    .lo_in  (work_lo),
    .operand(operand_mag),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Sign fix-up and special cases applied to the finished magnitudes
  always_comb begin
    prod_mag = {work_hi, work_lo};
    prod_fix = neg_prod ? -prod_mag : prod_mag;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else if (div_ovf) begin
        fix_hi = '0;
        fix_lo = MIN_VAL;
      end else begin
        fix_hi = neg_rem  ? -work_hi : work_hi;
        fix_lo = neg_prod ? -work_lo : work_lo;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: state elements are written with <= so every register samples
    // pre-edge values regardless of statement order.
    if (rst) state <= MDU_IDLE;
    else     state <= state_next;
  end

  // Operand capture on accept, then one datapath step per ITER cycle
  always_ff @(posedge clk) begin
    // NOTE: the working registers are reset as well, so a reset mid-operation
    // leaves no stale operand or partial result behind.
    if (rst) begin
      count       <= '0;
      op_div      <= 1'b0;
      a_q         <= '0;
      operand_mag <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      neg_prod    <= 1'b0;
      neg_rem     <= 1'b0;
      div_zero    <= 1'b0;
      div_ovf     <= 1'b0;
    end else if (accept && !fast) begin
      count       <= CW'(WIDTH - 1);
      op_div      <= op_is_div(op);
      a_q         <= a;
      operand_mag <= op_is_div(op) ? b_mag : a_mag;
      work_hi     <= '0;
      work_lo     <= op_is_div(op) ? a_mag : b_mag;
      neg_prod    <= a_neg ^ b_neg;
      neg_rem     <= a_neg;
      div_zero    <= (b == '0);
      div_ovf     <= in_signed && (a == MIN_VAL) && (b == '1);
    end else if (state == MDU_ITER) begin
      count       <= count - 1'b1;
      work_hi     <= step_hi;
      work_lo     <= step_lo;
    end
  end

  // Result registers: hold the last result until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if ((state == MDU_FIX) && !flush) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
`ifdef MDU_FAST_MUL_EN
    else if (fast) begin
      hi <= fast_prod[2*WIDTH-1:WIDTH];
      lo <= fast_prod[WIDTH-1:0];
    end
`endif
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO and the
// expected done cycle; a monitor checks busy, done timing, results and that
// hi/lo hold between completions.
module tb_muldiv_unit;

  localparam int W        = 32;
  localparam int ITER_LAT = W + 2;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           issue;
    int           due;
    string        name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           cyc     = 0;
  int           n_vec   = 0;
  int           n_err   = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model straight from the arithmetic definitions
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              qq, rr;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      OP_MULT:  r = sx * sy;
      OP_MULTU: r = ux * uy;
      OP_DIVU: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {x % y, x / y};
      end
      default: begin
        if (y == 0)                                        r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          qq = int'(sx / sy);
          rr = int'(sx % sy);
          r  = {rr, qq};
        end
      end
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
    if (o == OP_MULT || o == OP_MULTU) return 1;
`endif
    return ITER_LAT;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && cyc > q[0].issue && cyc < q[0].due) check("busy", 64'(busy), 64'd1);
      else                                                    check("busy", 64'(busy), 64'd0);
      if (done) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
        end else begin
          mon_e = q.pop_front();
          check($sformatf("%s.hi", mon_e.name), 64'(hi), 64'(mon_e.hi));
          check($sformatf("%s.lo", mon_e.name), 64'(lo), 64'(mon_e.lo));
          check($sformatf("%s.done_cycle", mon_e.name), 64'(cyc), 64'(mon_e.due));
          last_hi = mon_e.hi;
          last_lo = mon_e.lo;
        end
      end else begin
        check("hold_hi", 64'(hi), 64'(last_hi));
        check("hold_lo", 64'(lo), 64'(last_lo));
        if (q.size() > 0 && cyc >= q[0].due) begin
          mon_e = q.pop_front();
          n_vec++;
          n_err++;
          $display("FAIL %s.missing_done at cycle %0d: got done=0, expected 1", mon_e.name, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string nm);
    logic [63:0] r;
    exp_t        e;
    r       = ref_model(o, x, y);
    op      = o;
    a       = x;
    b       = y;
    start   = 1'b1;
    e.hi    = r[63:32];
    e.lo    = r[31:0];
    e.issue = cyc;
    e.due   = cyc + lat(o);
    e.name  = nm;
    q.push_back(e);
    step();
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 200;
    while (q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle_timeout at cycle %0d: got pending=%0d, expected 0", cyc, q.size());
      q.delete();
    end
  endtask

  // Advance to the cycle in which the oldest pending op should show done
  task automatic wait_due();
    int budget;
    budget = 200;
    while (q.size() > 0 && cyc != q[0].due && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_due_timeout at cycle %0d: got no due cycle, expected one", cyc);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7, 0))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'($urandom_range(20, 0));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    // Directed arithmetic cases
    drive_op(OP_MULTU, 32'd7, 32'd3, "multu_7x3");                   wait_idle();
    drive_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, "mult_m1x2");           wait_idle();
    drive_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");  wait_idle();
    drive_op(OP_MULT, 32'd5, 32'hFFFF_FFFD, "mult_5xm3");           wait_idle();
    drive_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");             wait_idle();
    drive_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_m2");             wait_idle();
    drive_op(OP_DIVU, 32'd7, 32'd0, "divu_by0");                    wait_idle();
    drive_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, "div_m5_by0");           wait_idle();
    drive_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");      wait_idle();

    // Start pulsed mid-operation is ignored
    drive_op(OP_DIVU, 32'd100, 32'd7, "divu_midstart");
    repeat (4) step();
    op    = OP_MULT;
    a     = 32'd123;
    b     = 32'd456;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();

    // Back-to-back: start in the done cycle
    drive_op(OP_DIV, 32'd1000, 32'hFFFF_FFDF, "div_b2b_first");
    wait_due();
    drive_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, "divu_b2b_second");
    wait_idle();

    // Flush at cycle 10 of a DIV, new start right after
    drive_op(OP_DIV, 32'd12345, 32'd67, "div_flushed");
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    q.delete(0);
    drive_op(OP_DIVU, 32'd99, 32'd10, "divu_after_flush");
    wait_idle();

    // Flush beats start in the done cycle
    drive_op(OP_MULTU, 32'd11, 32'd13, "multu_flush_start");
    wait_due();
    op    = OP_DIVU;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    repeat (3) step();

    // Flush while idle has no effect
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();

    // Reset mid-operation: full reset values, no done
    drive_op(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, "multu_reset");
    repeat (5) step();
    rst = 1'b1;
    step();
    rst     = 1'b0;
    q.delete();
    last_hi = '0;
    last_lo = '0;
    step();

    // Randomized traffic, idle gaps mixed with back-to-back issue
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] rx, ry;
      ro = 2'($urandom);
      rx = pick();
      ry = pick();
      if ($urandom_range(2, 0) == 0) wait_due();
      else                           wait_idle();
      drive_op(ro, rx, ry, $sformatf("rand%0d", i));
    end
    wait_idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
